// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ message streams.
// Grants are locked per message, with an idle gap after each message and a stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_tx_start,
  output logic [DATA_BITS-1:0]           o_tx_data,
  input  logic                           i_tx_busy,
  output logic                           o_abort,
  output logic                           o_busy
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SumW   = IdxW + 1;
  localparam int unsigned CntMax = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
  localparam logic [CntW-1:0] ToLast  = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast = (GAP_CYCLES == 0) ? '0 : CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitBusy, StWaitDone, StGap} state_e;

  // With no gap configured, a finished or aborted message returns straight to IDLE.
  localparam state_e StPostMsg = (GAP_CYCLES == 0) ? StIdle : StGap;
  localparam logic   PostBusy  = (GAP_CYCLES != 0);

  state_e                r_state;
  logic [IdxW-1:0]       r_ptr;
  logic [NUM_REQ-1:0]    r_grant;
  logic [CntW-1:0]       r_cnt;
  logic                  r_last;
  logic                  r_tx_start;
  logic [DATA_BITS-1:0]  r_tx_data;
  logic                  r_abort;
  logic                  r_busy;

  logic                  w_any;
  logic [IdxW-1:0]       w_win;
  logic [SumW-1:0]       w_sum;
  logic                  w_valid;
  logic [DATA_BITS-1:0]  w_data;
  logic                  w_last;
  logic                  w_xfer;

  // Scan from ptr+NUM_REQ-1 down to ptr so the nearest valid requester at/after ptr wins.
  always_comb begin
    w_win = '0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + SumW'(k);
      if (w_sum >= SumW'(NUM_REQ)) w_sum = w_sum - SumW'(NUM_REQ);
      if (i_req_valid[w_sum[IdxW-1:0]]) w_win = w_sum[IdxW-1:0];
    end
  end

  assign w_any = |i_req_valid;

  always_comb begin
    w_valid = 1'b0;
    w_data  = '0;
    w_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_valid = i_req_valid[i];
        w_data  = i_req_data[i*DATA_BITS +: DATA_BITS];
        w_last  = i_req_last[i];
      end
    end
  end

  assign o_req_ready = (r_state == StLoad && !i_tx_busy) ? r_grant : '0;
  assign w_xfer      = (r_state == StLoad) && w_valid && !i_tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_abort    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_abort    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant <= NUM_REQ'(1) << w_win;
            r_ptr   <= (w_win == IdxW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          if (w_xfer) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_data;
            r_last     <= w_last;
            r_cnt      <= '0;
            r_state    <= StWaitBusy;
          end else if (TIMEOUT != 0 && r_cnt == ToLast) begin
            r_abort <= 1'b1;
            r_grant <= '0;
            r_cnt   <= '0;
            r_busy  <= PostBusy;
            r_state <= StPostMsg;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitBusy: begin
          if (i_tx_busy) r_state <= StWaitDone;
        end
        StWaitDone: begin
          if (!i_tx_busy) begin
            r_cnt <= '0;
            if (r_last) begin
              r_grant <= '0;
              r_busy  <= PostBusy;
              r_state <= StPostMsg;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_grant    = r_grant;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_abort    = r_abort;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message traffic checked against a
// transaction-level round-robin model; uart_tx is modelled as a fixed-length busy window.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned GAP   = 16;
  localparam int unsigned TMO   = 20;
  localparam int unsigned FRAME = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic              tx_start, tx_busy, abort, busy, bp_force;
  logic [DW-1:0]     tx_data;

  int n_chk = 0;
  int n_bad = 0;

  logic [8:0]      mem [NREQ][64];
  int              len [NREQ];
  int              pos [NREQ];
  int              streak [NREQ];
  logic [NREQ-1:0] drop;
  logic            hold0, jitter;
  int              exp_byte[$];
  int              exp_ob[$];
  int              exp_own[$];
  int              ei, mi, nstart, lock_bad;
  int unsigned     bcnt;

  uart_tx_arbiter #(
    .NUM_REQ    (NREQ),
    .DATA_BITS  (DW),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_abort     (abort),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy from the cycle after tx_start for FRAME cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt <= 0;
    else if (tx_start) bcnt <= FRAME;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || bp_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic all_sent();
    for (int i = 0; i < NREQ; i++) if (pos[i] < len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic put(input int r, input logic [7:0] b, input logic last);
    mem[r][len[r]] = {last, b};
    len[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (pos[i] < len[i]) begin
        req_valid[i]        = !drop[i] && !(i == 0 && hold0);
        req_data[i*DW +: DW] = mem[i][pos[i]][7:0];
        req_last[i]         = mem[i][pos[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    bp_force = 1'b0; hold0 = 1'b0; jitter = 1'b0; drop = '0;
    for (int i = 0; i < NREQ; i++) begin len[i] = 0; pos[i] = 0; streak[i] = 0; end
    exp_byte.delete(); exp_ob.delete(); exp_own.delete();
    #1;
    check("rst_state", {grant, req_ready, tx_start, tx_data, abort, busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Message-level model: every requester with data left is pending at each arbitration; the
  // winner is the first pending index at or after ptr, and its whole message goes out unbroken.
  task automatic build_expected();
    int mp[NREQ];
    int ptr, w;
    logic [8:0] b;
    exp_byte.delete(); exp_ob.delete(); exp_own.delete();
    for (int i = 0; i < NREQ; i++) mp[i] = 0;
    ptr = 0;
    while (1) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ptr + k) % NREQ;
        if (w < 0 && mp[idx] < len[idx]) w = idx;
      end
      if (w < 0) break;
      exp_own.push_back(w);
      do begin
        b = mem[w][mp[w]];
        exp_byte.push_back(int'(b[7:0]));
        exp_ob.push_back(w);
        mp[w]++;
      end while (!b[8] && mp[w] < len[w]);
      ptr = (w + 1) % NREQ;
    end
  endtask

  task automatic run_traffic(input int budget);
    int cyc, zrun, gb;
    logic done, seen, pbusy;
    logic [NREQ-1:0] hs, pgrant;
    ei = 0; mi = 0; nstart = 0; lock_bad = 0;
    cyc = 0; zrun = 0; gb = 0; done = 1'b0; seen = 1'b0; pbusy = 1'b0; pgrant = '0;
    drive();
    while (!done && cyc < budget) begin
      @(negedge clk);
      if ((req_ready & ~grant) != '0) lock_bad++;
      if (tx_start) begin
        if (ei < exp_byte.size()) begin
          check("tx_data", 32'(tx_data), exp_byte[ei]);
          check("tx_owner", 32'(grant), 32'(onehot(exp_ob[ei])));
        end else begin
          check("tx_extra", ei, exp_byte.size());
        end
        ei++;
        nstart++;
      end
      if (grant != '0 && pgrant == '0) begin
        if (mi < exp_own.size()) check("grant", 32'(grant), 32'(onehot(exp_own[mi])));
        else check("grant_extra", mi, exp_own.size());
        if (seen) check("gap_idle", zrun, GAP + 1);
        seen = 1'b1;
        mi++;
      end
      if (grant == '0) zrun++; else zrun = 0;
      if (grant == '0 && busy) gb++; else if (grant != '0) gb = 0;
      if (pbusy && !busy) check("gap_len", gb, GAP);
      pgrant = grant;
      pbusy  = busy;
      hs     = req_valid & req_ready;
      done   = (ei >= exp_byte.size()) && !busy && all_sent();
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (hs[i]) pos[i]++;
      if (hold0 && nstart >= 1) hold0 = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (jitter && grant[i] && pos[i] < len[i] && streak[i] < 4 && $urandom_range(0, 3) == 0)
        begin
          drop[i] = 1'b1;
          streak[i]++;
        end else begin
          drop[i]   = 1'b0;
          streak[i] = 0;
        end
      end
      drive();
      cyc++;
    end
    check("bytes", ei, exp_byte.size());
    check("msgs", mi, exp_own.size());
    check("lock", lock_bad, 0);
  endtask

  initial begin
    int ab_at, nab, ns, bprdy, total;
    logic ok, bz;
    logic [7:0] got_data;
    logic [NREQ-1:0] g;

    // Single three-byte message from requester 2.
    do_reset();
    put(2, 8'h41, 1'b0); put(2, 8'h42, 1'b0); put(2, 8'h43, 1'b1);
    build_expected();
    run_traffic(2000);

    // Round-robin between two always-pending requesters.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(0, 8'(8'h10 + i), 1'b1);
      put(1, 8'(8'h20 + i), 1'b1);
    end
    build_expected();
    run_traffic(3000);

    // Lock: requester 0 raises valid only after requester 3's first byte has started.
    do_reset();
    put(3, 8'h31, 1'b0); put(3, 8'h32, 1'b1); put(0, 8'h01, 1'b1);
    hold0 = 1'b1;
    exp_own = '{3, 0};
    exp_byte = '{8'h31, 8'h32, 8'h01};
    exp_ob = '{3, 3, 0};
    run_traffic(2000);

    // Timeout: one non-last byte, then requester 1 goes silent.
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_5500; req_last = '0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (req_ready[1]) ok = 1'b1; end
    check("to_ready", ok, 1);
    @(posedge clk); #1; req_valid = '0; req_data = '0;
    ok = 1'b0; got_data = '0;
    for (int c = 0; c < 5 && !ok; c++) begin
      @(negedge clk);
      if (tx_start) begin ok = 1'b1; got_data = tx_data; end
    end
    check("to_start", ok, 1);
    check("to_data", got_data, 8'h55);
    ok = 1'b0;
    for (int c = 0; c < 5 && !ok; c++) begin @(negedge clk); if (tx_busy) ok = 1'b1; end
    ok = 1'b0;
    for (int c = 0; c < FRAME + 5 && !ok; c++) begin @(negedge clk); if (!tx_busy) ok = 1'b1; end
    check("to_busy_fall", ok, 1);
    // LOAD is re-entered one cycle after tx_busy falls, abort follows TMO cycles later.
    ab_at = -1; nab = 0; ns = 0; g = '1; bz = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (n > 0) @(negedge clk);
      if (abort) begin
        nab++;
        if (ab_at < 0) begin ab_at = n; g = grant; bz = busy; end
      end
      if (tx_start) ns++;
    end
    check("to_abort_time", ab_at, TMO + 1);
    check("to_abort_width", nab, 1);
    check("to_grant_rel", g, 0);
    check("to_busy_gap", bz, 1);
    check("to_no_start", ns, 0);
    check("to_idle", {grant, busy}, 0);

    // Backpressure: tx_busy held high while the owner sits in LOAD.
    do_reset();
    bp_force = 1'b1;
    req_valid = 4'b0001; req_data = 32'h0000_0099; req_last = 4'b0001;
    bprdy = 0; ns = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) bprdy++;
      if (tx_start) ns++;
    end
    check("bp_ready", bprdy, 0);
    check("bp_nostart", ns, 0);
    check("bp_grant", grant, 4'b0001);
    @(posedge clk); #1; bp_force = 1'b0;
    @(negedge clk);
    check("bp_rel_ready", req_ready, 4'b0001);
    check("bp_rel_nostart", tx_start, 0);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    check("bp_start", tx_start, 1);
    check("bp_data", tx_data, 8'h99);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin @(negedge clk); if (!busy) ok = 1'b1; end
    check("bp_drain", ok, 1);

    // Reset while the serializer is mid-frame, then a simultaneous 0/2 request.
    do_reset();
    req_valid = 4'b0010; req_data = 32'h0000_A500; req_last = 4'b0010;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin @(negedge clk); if (tx_start) ok = 1'b1; end
    check("rm_start", ok, 1);
    @(posedge clk); #1; req_valid = '0;
    repeat (4) @(negedge clk);
    check("rm_pre", {tx_busy, tx_data}, {1'b1, 8'hA5});
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rm_out", {grant, req_ready, tx_start, tx_data, abort, busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_last = '0; req_data = '0;
    put(0, 8'hC0, 1'b1); put(2, 8'hC2, 1'b1);
    build_expected();
    run_traffic(2000);

    // Randomized traffic with short valid bubbles from the owner.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      total = 0;
      for (int q = 0; q < NREQ; q++) begin
        int nm;
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) begin
          int nb;
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) put(q, 8'($urandom), b == nb - 1);
          total++;
        end
      end
      if (total == 0) put(0, 8'h5A, 1'b1);
      jitter = 1'b1;
      build_expected();
      run_traffic(8000);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer between `NUM_REQ` requesters. Each requester streams a multi-byte message through a valid/ready handshake. The arbiter locks the grant for the whole message, which ends with the `last` byte. It sequences each byte into the serializer with a `tx_start` pulse and tracks `tx_busy`. It inserts an idle gap between messages and aborts a stalled message after a timeout.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_BITS`, 8: byte width, matching `uart_tx`.
- `GAP_CYCLES`, 16: idle clk cycles inserted after every message before the next arbitration. 0 means no gap.
- `TIMEOUT`, 65535: clk cycles a granted requester may hold `req_valid` low mid-message before abort. 0 disables the timeout.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*DATA_BITS: byte of requester i on bits [i*DATA_BITS +: DATA_BITS].
- `req_last` in NUM_REQ: marks the final byte of the message.
- `req_ready` out NUM_REQ: byte accepted when `req_valid[i]` and `req_ready[i]` are both high on a clk edge.
- `grant` out NUM_REQ: one-hot current owner, registered. All-zero when no requester owns the serializer.
- `tx_start` out 1: one-cycle pulse to `uart_tx`.
- `tx_data` out DATA_BITS: byte for `uart_tx`, valid with `tx_start` and held until the next start.
- `tx_busy` in 1: high while `uart_tx` shifts a frame. It rises the cycle after `tx_start`.
- `abort` out 1: one-cycle pulse when a message is killed by timeout.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:** if any `req_valid` is high, pick the first requester at or after `ptr`, searching upward mod NUM_REQ.
  - Register that requester in `grant`, set `ptr` to the winner+1 mod NUM_REQ, and go to LOAD.
  - `ptr` resets to 0, so requester 0 has highest priority first.
- **LOAD:** `req_ready[i] = grant[i] & !tx_busy`. It is combinational and independent of `req_valid`.
  - On a transfer: next cycle `tx_start`=1, `tx_data`=accepted byte, `last_q`=`req_last`; go to WAIT_BUSY.
  - Timeout counter counts LOAD cycles without a transfer and clears on each transfer.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): `abort`=1 for one cycle, go to GAP.
- **WAIT_BUSY:** wait for `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `tx_busy`=0. Then go to GAP if `last_q`, else back to LOAD for the next byte. The grant is held.
- **GAP:** `grant`=0 and a counter runs GAP_CYCLES cycles. When it expires, or immediately if GAP_CYCLES=0, go to IDLE.
- **Message lock:** other requesters' `req_valid` is ignored until the owner's last byte completes or the message aborts. Their `req_ready` stays 0.
- A requester dropping `req_valid` mid-message keeps the grant. Only the timeout releases it.
- **Reset, asynchronous, any state:**
  - State returns to IDLE; `ptr` = 0.
  - All outputs reset to 0: `grant`, `req_ready`, `tx_start`, `tx_data`, `abort`, `busy`.
  - Counters clear; `last_q` = 0.
- Counter widths: `$clog2(max(GAP_CYCLES,TIMEOUT)+1)`. No wrap is possible, because each counter stops at its limit.

## Timing
- `req_valid[i]` rises at edge t in IDLE. Then `grant[i]`=1 from t+1, and `req_ready[i]`=1 from t+1 if `tx_busy`=0.
- A transfer at edge t+1 gives `tx_start` high during t+1..t+2, with `tx_data` valid.
- Minimum spacing between bytes of one message is one `uart_tx` frame + 3 cycles.
- Message to next message spacing is at least GAP_CYCLES + 1 cycles after `tx_busy` falls.
- `abort` fires exactly TIMEOUT cycles after entering LOAD, or after the last transfer, with no transfer in between.
- Simultaneous requests in IDLE are resolved in one cycle by `ptr`. A requester asserting on the same edge the gap expires is eligible immediately.

## Test plan
- **Single message:** NUM_REQ=4, requester 2 sends 0x41, 0x42, 0x43 with last on 0x43.
  - Required: exactly three `tx_start` pulses with those bytes in order.
  - `grant`=4'b0100 throughout, then 0 for 16 cycles, then IDLE.
- **Round-robin:** requesters 0 and 1 each keep a 1-byte message pending continuously.
  - Required: grant order 0,1,0,1…. Neither requester is granted twice in a row.
- **Lock:** requester 3 is mid-message (byte 1 of 2) when requester 0 asserts valid.
  - Required: `req_ready[0]`=0 until requester 3's last byte completes plus the gap; then `grant`=4'b0001.
- **Timeout:** TIMEOUT=20; requester 1 sends one non-last byte, then drops valid.
  - Required: `abort` pulses 20 cycles after re-entering LOAD; `grant`→0; no further `tx_start`.
- **Backpressure:** `tx_busy` forced high while in LOAD.
  - Required: `req_ready`=0 and no transfer. Release → transfer → `tx_start` the following cycle.
- **Reset mid-frame:** assert `rst_n`=0 in WAIT_DONE.
  - Required: all outputs are 0 immediately. After release, requester 0 wins a simultaneous 0/2 request.
